pipelined_add_sub: RTL and testbench
====================================

# pipelined_add_sub

Parametrised, pipelined integer adder/subtractor with a valid/ready handshake and carry, overflow and zero flags. It generalises the single-bit full adder to WIDTH bits, split into STAGES ripple segments with one register bank between segments. It is the arithmetic core behind the ALU's add/sub path when the design moves from single-cycle to a pipelined datapath.

## Interface
- WIDTH, 32, operand and result width in bits; must be ≥ 1.
- STAGES, 4, number of pipeline stages; must be ≥ 1 and must divide WIDTH exactly. Segment width is CHUNK = WIDTH/STAGES.

- clk  in  1  rising-edge clock, the only clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand beat is present.
- in_ready  out  1  the block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in for add; borrow-in for subtract.
- sub  in  1  0 selects add, 1 selects subtract.
- out_valid  out  1  a result is present.
- out_ready  in  1  downstream takes the result this cycle.
- sum  out  WIDTH  result.
- cout  out  1  carry-out of the MSB.
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  high when sum is all zeros.

## Operation
- A beat transfers on an interface when valid and ready are both high in the same cycle. Input beats are accepted on in_valid && in_ready; results leave on out_valid && out_ready.
- Add (sub=0): {cout, sum} = a + b + cin.
- Subtract (sub=1): {cout, sum} = a + ~b + ~cin, which equals a − b − cin. For subtract, cout=1 means no borrow.
- ovf = (a_msb == b_eff_msb) && (sum_msb != a_msb), where b_eff = sub ? ~b : b.
- zero = (sum == 0). It depends only on sum and ignores cout.
- Stage k (0..STAGES−1) computes bits [k·CHUNK +: CHUNK] using the carry registered by stage k−1. Stage 0 uses the effective carry-in.
- Upper operand bits travel down the pipeline with their beat. Completed lower sum bits are also carried forward.
- Each stage holds a valid bit.
  - stage_ready[k] = !valid[k] || stage_ready[k+1], with stage_ready[STAGES] = out_ready.
  - in_ready = stage_ready[0].
  - Bubbles collapse, so a stage advances whenever the stage after it is free.
- Results leave in strict acceptance order. No beat is ever dropped or duplicated.
- out_valid = valid[STAGES−1]. The outputs sum, cout, ovf and zero come from the last stage's registers.

## Timing
- Reset (rst_n=0 sampled at a clk edge) clears every valid bit, sum, cout, ovf and zero to 0. in_ready is 1 in the cycle after reset is released.
- Reset mid-operation flushes all in-flight beats. No result for those beats ever appears.
- Latency: a beat accepted at edge t gives out_valid=1 after edge t+STAGES−1 when there are no stalls. For STAGES=1 the result is registered once: accept at edge t, out_valid in the following cycle.
- Throughput is one beat per cycle while out_ready=1.
- Stall: while out_valid && !out_ready, sum, cout, ovf and zero hold stable.
  - Upstream stages keep filling until every stage is occupied.
  - in_ready drops to 0 in the same cycle that all STAGES stages are valid and out_ready=0.
- Accept and emit in the same cycle are legal; occupancy is then unchanged.
- in_ready depends combinationally on out_ready (a ready chain through the stages). There is no combinational path from in_valid to out_valid.
- Inputs are ignored when in_ready=0.

## Structure
- Shared package alu_pkg holds the operation encoding constants ADD=1'b0 and SUB=1'b1, and the default WIDTH.
- Sub-module add_slice: a CHUNK-bit combinational ripple segment with inputs a, b, cin and outputs s, co. It is instantiated once per stage.
- The top level holds the stage registers, the valid/ready chain, operand skew and flag generation.
- Flags are computed in the last stage from the registered MSB operands and the sum.

## Test plan
- WIDTH=8, STAGES=2, add 0xFF+0x01, cin=0 -> sum=0x00, cout=1, zero=1, ovf=0, with out_valid exactly 2 cycles after accept.
- Add 0x7F+0x01, cin=0 -> sum=0x80, ovf=1, cout=0. Then sub 0x05−0x07, cin=0 -> sum=0xFE, cout=0, ovf=0. Then sub 0x80−0x01 -> sum=0x7F, ovf=1, cout=1.
- Back-pressure: 4 back-to-back beats with out_ready=0 for 4 cycles.
  - in_ready falls once 2 beats are held.
  - Outputs stay stable while stalled.
  - After out_ready=1, all 4 results emerge in order with no loss.
- Reset mid-flight: assert rst_n=0 for one cycle with 2 beats in the pipe -> out_valid=0 and all outputs 0 next cycle; no stale result later.
- WIDTH=1, STAGES=1, all 16 combinations of a, b, cin, sub -> sum and cout match the full-adder truth table. For sub=1, cout is the inverted borrow.
- WIDTH=32, STAGES=4, 10,000 random beats with random in_valid/out_ready -> every result matches the reference model, order preserved, counts equal.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared operation encoding and default sizing for the add/sub datapath
package alu_pkg;

  localparam int   DEFAULT_WIDTH  = 32;
  localparam int   DEFAULT_STAGES = 4;

  // Operation select encoding for the sub input
  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

endpackage

// File: rtl/add_slice.sv
// rtl/add_slice.sv - combinational ripple-carry segment of W bits
module add_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W:0] carry;

  // Chain of full adders, carry rippling from bit 0 upward
  always_comb begin
    carry    = '0;
    s        = '0;
    carry[0] = cin;
    for (int i = 0; i < W; i++) begin
      s[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign co = carry[W];

endmodule

// File: rtl/pipelined_add_sub.sv
// rtl/pipelined_add_sub.sv - pipelined WIDTH-bit adder/subtractor with valid/ready and flags
module pipelined_add_sub
  import alu_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  // Per-stage registers: operands travel with the beat, b is already inverted for subtract
  logic [STAGES-1:0] valid_q;
  logic [WIDTH-1:0]  a_q     [STAGES];
  logic [WIDTH-1:0]  b_q     [STAGES];
  logic [WIDTH-1:0]  sum_q   [STAGES];
  logic              carry_q [STAGES];
  logic              ovf_q;
  logic              zero_q;

  // What each stage sees at its input: the previous stage's registers, or the ports for stage 0
  logic [STAGES-1:0] src_v;
  logic [WIDTH-1:0]  src_a   [STAGES];
  logic [WIDTH-1:0]  src_b   [STAGES];
  logic [WIDTH-1:0]  src_sum [STAGES];
  logic              src_c   [STAGES];

  logic [CHUNK-1:0]  slice_s  [STAGES];
  logic              slice_co [STAGES];
  logic [WIDTH-1:0]  sum_d    [STAGES];
  logic [STAGES:0]   stage_ready;
  logic              ovf_d;
  logic              zero_d;

  // Select stage inputs; subtract becomes a + ~b + ~cin at the pipeline entry
  always_comb begin
    src_v[0]   = in_valid;
    src_a[0]   = a;
    src_b[0]   = (sub == SUB) ? ~b : b;
    src_c[0]   = (sub == SUB) ? ~cin : cin;
    src_sum[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k]   = valid_q[k-1];
      src_a[k]   = a_q[k-1];
      src_b[k]   = b_q[k-1];
      src_c[k]   = carry_q[k-1];
      src_sum[k] = sum_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    add_slice #(.W(CHUNK)) u_slice (
      .a   (src_a[k][k*CHUNK +: CHUNK]),
      .b   (src_b[k][k*CHUNK +: CHUNK]),
      .cin (src_c[k]),
      .s   (slice_s[k]),
      .co  (slice_co[k])
    );
  end

  // Merge each stage's freshly computed chunk into the partial sum it inherited
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      sum_d[k]                    = src_sum[k];
      sum_d[k][k*CHUNK +: CHUNK]  = slice_s[k];
    end
  end

  // Flags for the final stage, from the MSB operands it receives and the completed sum
  always_comb begin
    ovf_d  = (src_a[LAST][WIDTH-1] == src_b[LAST][WIDTH-1]) &&
             (sum_d[LAST][WIDTH-1] != src_a[LAST][WIDTH-1]);
    zero_d = (sum_d[LAST] == '0);
  end

  // Ready chain from the output back to the input; an empty stage is always ready
  always_comb begin
    stage_ready[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      stage_ready[k] = !valid_q[k] || stage_ready[k+1];
    end
  end

  // Advance every stage whose successor is free; data registers load only with a real beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
        carry_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (stage_ready[k]) begin
          valid_q[k] <= src_v[k];
          if (src_v[k]) begin
            a_q[k]     <= src_a[k];
            b_q[k]     <= src_b[k];
            sum_q[k]   <= sum_d[k];
            carry_q[k] <= slice_co[k];
          end
        end
      end
      if (stage_ready[LAST] && src_v[LAST]) begin
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign in_ready  = stage_ready[0];
  assign out_valid = valid_q[LAST];
  assign sum       = sum_q[LAST];
  assign cout      = carry_q[LAST];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb/tb_pipelined_add_sub.sv - scoreboard bench for pipelined_add_sub at three sizes
module tb_pipelined_add_sub;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- 8-bit, 2-stage instance ----------------
  logic       rst8_n, in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8;
  logic [7:0] a8, b8, sum8;
  logic       cout8, ovf8, zero8;

  pipelined_add_sub #(.WIDTH(8), .STAGES(2)) dut8 (
    .clk(clk), .rst_n(rst8_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8)
  );

  // ---------------- 1-bit, 1-stage instance ----------------
  logic       rst_n, in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1;
  logic [0:0] a1, b1, sum1;
  logic       cout1, ovf1, zero1;

  pipelined_add_sub #(.WIDTH(1), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .sub(sub1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .ovf(ovf1), .zero(zero1)
  );

  // ---------------- 32-bit, 4-stage instance ----------------
  logic        in_valid32, in_ready32, cin32, sub32, out_valid32, out_ready32;
  logic [31:0] a32, b32, sum32;
  logic        cout32, ovf32, zero32;

  pipelined_add_sub #(.WIDTH(32), .STAGES(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .cin(cin32), .sub(sub32),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .sum(sum32), .cout(cout32), .ovf(ovf32), .zero(zero32)
  );

  // Reference: exact integer arithmetic, packed as {cout, ovf, zero, sum[31:0]}
  function automatic logic [34:0] model(int w, logic [31:0] a, logic [31:0] b, logic cin, logic sub);
    longint m, ua, ub, sa, sb, c, u, s;
    logic   co, ov;
    logic [31:0] r;
    m  = longint'(1) << w;
    ua = longint'({32'b0, a}) & (m - 1);
    ub = longint'({32'b0, b}) & (m - 1);
    c  = cin ? 1 : 0;
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (!sub) begin
      u  = ua + ub + c;
      co = (u >= m);
      if (co) u = u - m;
      s  = sa + sb + c;
    end else begin
      u  = ua - ub - c;
      co = (u >= 0);
      if (!co) u = u + m;
      s  = sa - sb - c;
    end
    ov = (s < -(m / 2)) || (s > m / 2 - 1);
    r  = u[31:0];
    return {co, ov, (r == 32'd0), r};
  endfunction

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Scoreboards and beat counters
  logic [34:0] exp8[$];
  logic [34:0] exp1[$];
  logic [34:0] exp32[$];
  int n_out8 = 0, n_out1 = 0, n_out32 = 0, n_acc32 = 0;

  // Monitors: compare every emitted result with the oldest expected, then log accepted beats
  always @(negedge clk) begin
    if (rst8_n && out_valid8 && out_ready8) begin
      n_out8++;
      if (exp8.size() == 0) check("dut8_unexpected_out", 64'(sum8), 64'hDEAD);
      else check("dut8_result", 64'({cout8, ovf8, zero8, 24'b0, sum8}), 64'(exp8.pop_front()));
    end
    if (rst8_n && in_valid8 && in_ready8)
      exp8.push_back(model(8, {24'b0, a8}, {24'b0, b8}, cin8, sub8));
  end

  always @(negedge clk) begin
    if (rst_n && out_valid1 && out_ready1) begin
      n_out1++;
      if (exp1.size() == 0) check("dut1_unexpected_out", 64'(sum1), 64'hDEAD);
      else check("dut1_result", 64'({cout1, ovf1, zero1, 31'b0, sum1}), 64'(exp1.pop_front()));
    end
    if (rst_n && in_valid1 && in_ready1)
      exp1.push_back(model(1, {31'b0, a1}, {31'b0, b1}, cin1, sub1));
  end

  always @(negedge clk) begin
    if (rst_n && out_valid32 && out_ready32) begin
      n_out32++;
      if (exp32.size() == 0) check("dut32_unexpected_out", 64'(sum32), 64'hDEAD);
      else check("dut32_result", 64'({cout32, ovf32, zero32, sum32}), 64'(exp32.pop_front()));
    end
    if (rst_n && in_valid32 && in_ready32) begin
      n_acc32++;
      exp32.push_back(model(32, a32, b32, cin32, sub32));
    end
  end

  // Present one beat on the 8-bit instance; called just after a rising edge, returns likewise
  task automatic send8(logic [7:0] a, logic [7:0] b, logic cin, logic sub);
    bit ok;
    a8 = a; b8 = b; cin8 = cin; sub8 = sub; in_valid8 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready8) ok = 1'b1;
      else @(posedge clk);
    end
    if (!ok) check("send8_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst8_n = 1'b0; rst_n = 1'b0;
    in_valid8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0; out_ready8 = 1;
    in_valid1 = 0; a1 = 0; b1 = 0; cin1 = 0; sub1 = 0; out_ready1 = 1;
    in_valid32 = 0; a32 = 0; b32 = 0; cin32 = 0; sub32 = 0; out_ready32 = 1;
    repeat (3) @(posedge clk);
    #1 rst8_n = 1'b1; rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid8), 64'd0);
    check("rst_outputs", 64'({cout8, ovf8, zero8, sum8}), 64'd0);
    check("rst_in_ready", 64'(in_ready8), 64'd1);
    check("rst32_state", 64'({in_ready32, out_valid32, cout32, ovf32, zero32, sum32}), 64'h10_0000_0000);

    // Latency: 0xFF + 0x01, result visible one edge after the accepting edge
    @(posedge clk); #1;
    a8 = 8'hFF; b8 = 8'h01; cin8 = 0; sub8 = 0; in_valid8 = 1;
    @(negedge clk);
    check("lat_accept", 64'(in_ready8), 64'd1);
    @(posedge clk); #1 in_valid8 = 0;
    @(negedge clk);
    check("lat_not_early", 64'(out_valid8), 64'd0);
    @(negedge clk);
    check("lat_valid", 64'(out_valid8), 64'd1);
    check("lat_ff_plus_1", 64'({cout8, ovf8, zero8, sum8}), 64'({3'b101, 8'h00}));

    // Directed flag cases
    @(posedge clk); #1;
    send8(8'h7F, 8'h01, 0, 0);
    send8(8'h05, 8'h07, 0, 1);
    send8(8'h80, 8'h01, 0, 1);
    repeat (5) @(posedge clk); #1;

    // Back-pressure: two beats fill the pipe, in_ready falls, outputs hold
    base = n_out8;
    out_ready8 = 0;
    send8(8'h11, 8'h22, 1, 0);
    send8(8'h40, 8'h40, 0, 0);
    a8 = 8'h00; b8 = 8'h00; cin8 = 0; sub8 = 1; in_valid8 = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready8), 64'd0);
      check("stall_out_valid", 64'(out_valid8), 64'd1);
      if (exp8.size() > 0)
        check("stall_hold", 64'({cout8, ovf8, zero8, 24'b0, sum8}), 64'(exp8[0]));
    end
    @(posedge clk); #1 out_ready8 = 1;
    send8(8'h00, 8'h00, 0, 1);
    send8(8'hC3, 8'h3C, 1, 1);
    repeat (6) @(posedge clk); #1;
    check("bp_count", 64'(n_out8 - base), 64'd4);
    check("bp_drained", 64'(exp8.size()), 64'd0);

    // Reset with two beats in flight
    base = n_out8;
    out_ready8 = 0;
    send8(8'h12, 8'h34, 0, 0);
    send8(8'h56, 8'h78, 1, 1);
    rst8_n = 0;
    exp8.delete();
    @(posedge clk); #1;
    rst8_n = 1; out_ready8 = 1;
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid8), 64'd0);
    check("flush_outputs", 64'({cout8, ovf8, zero8, sum8}), 64'd0);
    repeat (8) @(posedge clk); #1;
    check("flush_no_stale", 64'(n_out8 - base), 64'd0);

    // 1-bit exhaustive: all combinations of a, b, cin, sub
    for (int i = 0; i < 16; i++) begin
      a1 = i[3]; b1 = i[2]; cin1 = i[1]; sub1 = i[0]; in_valid1 = 1;
      @(posedge clk); #1;
    end
    in_valid1 = 0;
    repeat (4) @(posedge clk); #1;
    check("fa_count", 64'(n_out1), 64'd16);

    // 32-bit random traffic with random back-pressure
    for (int cyc = 0; cyc < 60000 && n_acc32 < 10000; cyc++) begin
      in_valid32  = ($urandom_range(0, 3) != 0);
      a32         = rand_op();
      b32         = rand_op();
      cin32       = $urandom_range(0, 1);
      sub32       = $urandom_range(0, 1);
      out_ready32 = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid32 = 0; out_ready32 = 1;
    for (int i = 0; i < 100 && exp32.size() != 0; i++) @(posedge clk);
    #1;
    check("rand_beats", 64'(n_acc32 >= 10000), 64'd1);
    check("rand_drained", 64'(exp32.size()), 64'd0);
    check("rand_count", 64'(n_out32), 64'(n_acc32));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
